// File: rtl/rng_roll_arbiter_if.sv
// Roll arbiter bus. The master side is the requester and generator environment.
// The slave side is the arbiter itself.
interface rng_roll_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0] i_req;
   logic [N_REQ-1:0] i_pause;
   logic [3:0]       i_rng_value;
   logic             o_rng_start;
   logic [N_REQ-1:0] o_grant;
   logic [3:0]       o_result;
   logic [N_REQ-1:0] o_result_valid;
   logic             o_busy;
   logic             o_paused;

   modport master (
      output i_req, i_pause, i_rng_value,
      input  o_rng_start, o_grant, o_result, o_result_valid, o_busy, o_paused
   );

   modport slave (
      input  i_req, i_pause, i_rng_value,
      output o_rng_start, o_grant, o_result, o_result_valid, o_busy, o_paused
   );
endinterface

// File: rtl/rng_roll_arbiter.sv
// rng_roll_arbiter: round-robin sharing of one start-pulse LFSR dice generator.
// The owner's roll is timed in running cycles. Pause and resume requests are
// forwarded as start pulses, and the final value is returned with a one-hot
// valid pulse.
module rng_roll_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned ROLL_CYCLES = 126000000,
   parameter int unsigned TMR_W       = 27,
   parameter int unsigned PAUSE_GUARD = 16
) (
   input logic               i_clk,
   input logic               i_rst_n,
   rng_roll_arbiter_if.slave bus
);

   localparam int unsigned      PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ROLL_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_GUARD = TMR_W'(ROLL_CYCLES - PAUSE_GUARD);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);
   localparam logic [PTR_W:0]   SUM_WRAP  = (PTR_W+1)'(N_REQ);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      ROLL,
      PAUSE_ON,
      PAUSED,
      PAUSE_OFF,
      CAPTURE
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] owner;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] result_valid;
   logic [3:0]       result;
   logic             rng_start;
   logic             busy;
   logic             paused;

   logic [PTR_W-1:0] pick;
   logic             pick_ok;
   logic [PTR_W:0]   sum;
   logic             owner_req;
   logic             owner_pause;

   assign owner_req   = bus.i_req[owner];
   assign owner_pause = bus.i_pause[owner];

   // Round-robin search: first requester at or after the pointer, wrapping.
   always_comb begin
      pick    = ptr;
      pick_ok = 1'b0;
      sum     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(i);
         if (sum >= SUM_WRAP) begin
            sum = sum - SUM_WRAP;
         end
         if (!pick_ok && bus.i_req[sum[PTR_W-1:0]]) begin
            pick    = sum[PTR_W-1:0];
            pick_ok = 1'b1;
         end
      end
   end

   // Roll sequencer. All outputs are registered. Start pulses exist only in
   // LAUNCH, PAUSE_ON and PAUSE_OFF. Every such state is followed by one
   // without a pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         timer        <= '0;
         ptr          <= '0;
         owner        <= '0;
         grant        <= '0;
         result_valid <= '0;
         result       <= '0;
         rng_start    <= 1'b0;
         busy         <= 1'b0;
         paused       <= 1'b0;
      end else begin
         rng_start    <= 1'b0;
         result_valid <= '0;
         case (state)
            IDLE: begin
               if (pick_ok) begin
                  owner     <= pick;
                  grant     <= N_REQ'(1) << pick;
                  busy      <= 1'b1;
                  rng_start <= 1'b1;
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               timer <= '0;
               state <= ROLL;
            end
            ROLL: begin
               if (timer >= TMR_LAST) begin
                  // Saturate at the last running cycle. The timer never wraps.
                  state <= CAPTURE;
               end else begin
                  timer <= timer + TMR_W'(1);
                  if (owner_pause && (timer < TMR_GUARD)) begin
                     rng_start <= 1'b1;
                     state     <= PAUSE_ON;
                  end
               end
            end
            PAUSE_ON: begin
               paused <= 1'b1;
               state  <= PAUSED;
            end
            PAUSED: begin
               // An owner that abandons its request is resumed automatically.
               // The generator cannot abort a roll, so the roll must finish.
               if (owner_pause || !owner_req) begin
                  paused    <= 1'b0;
                  rng_start <= 1'b1;
                  state     <= PAUSE_OFF;
               end
            end
            PAUSE_OFF: begin
               state <= ROLL;
            end
            CAPTURE: begin
               if (owner_req) begin
                  result       <= bus.i_rng_value;
                  result_valid <= N_REQ'(1) << owner;
               end
               ptr   <= (owner == PTR_LAST) ? '0 : owner + PTR_W'(1);
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_rng_start    = rng_start;
   assign bus.o_grant        = grant;
   assign bus.o_result       = result;
   assign bus.o_result_valid = result_valid;
   assign bus.o_busy         = busy;
   assign bus.o_paused       = paused;

endmodule

// File: tb/tb_rng_roll_arbiter.sv
// Testbench for rng_roll_arbiter. The generator output is a known function of
// the cycle number, so each captured value follows from when the roll was
// requested. Expected results are queued at stimulus time and then popped
// when a valid pulse appears.
module tb_rng_roll_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned RC = 20;
   localparam int unsigned TW = 5;
   localparam int unsigned PG = 4;

   typedef struct {
      int         cyc;
      logic [N-1:0] vld;
      logic [3:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_result = '0;
   exp_t       sb[$];

   rng_roll_arbiter_if #(.N_REQ(N)) bus ();

   rng_roll_arbiter #(
      .N_REQ(N),
      .ROLL_CYCLES(RC),
      .TMR_W(TW),
      .PAUSE_GUARD(PG)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] gen(input int c);
      logic [31:0] x;
      x = c;
      return x[3:0] ^ x[7:4] ^ 4'h6;
   endfunction

   assign bus.i_rng_value = gen(cyc);

   // The valid pulse is visible in cycle vcyc. The value was sampled in vcyc-1.
   task automatic push_exp(input int owner, input int vcyc);
      exp_t e;
      e.cyc = vcyc;
      e.vld = N'(1) << owner;
      e.val = gen(vcyc - 1);
      sb.push_back(e);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.i_req = '0;
      bus.i_pause = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.o_grant, bus.o_result_valid, bus.o_result, bus.o_rng_start, bus.o_busy, bus.o_paused} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h required 0",
                  {bus.o_grant, bus.o_result_valid, bus.o_result, bus.o_rng_start, bus.o_busy, bus.o_paused});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.o_grant, bus.o_result_valid, bus.o_rng_start, bus.o_busy, bus.o_paused} !== 11'd0) begin
         errors++;
         $display("FAIL idle_after_reset got grant=%b valid=%b start=%b busy=%b paused=%b required all 0",
                  bus.o_grant, bus.o_result_valid, bus.o_rng_start, bus.o_busy, bus.o_paused);
      end
   endtask

   task automatic test_round_robin;
      exp_t e;
      int c, ngrant, nstart, nvalid;
      logic [N-1:0] prev_grant;
      @(negedge clk);
      c = cyc;
      bus.i_req = '1;
      for (int j = 0; j < 5; j++) push_exp(j % 4, c + 23 + 23 * j);
      ngrant = 0; nstart = 0; nvalid = 0; prev_grant = '0;
      for (int k = 1; k <= 5 * 23 + 8; k++) begin
         @(negedge clk);
         if (bus.o_grant !== '0 && prev_grant === '0) begin
            checks++;
            if (bus.o_grant !== (N'(1) << (ngrant % 4)) || cyc != c + 1 + 23 * ngrant) begin
               errors++;
               $display("FAIL rr_grant got %b at offset %0d required %b at offset %0d",
                        bus.o_grant, cyc - c, N'(1) << (ngrant % 4), 1 + 23 * ngrant);
            end
            ngrant++;
         end
         prev_grant = bus.o_grant;
         if (bus.o_rng_start === 1'b1) begin
            checks++;
            if (cyc != c + 1 + 23 * nstart) begin
               errors++;
               $display("FAIL rr_start pulse at offset %0d required %0d", cyc - c, 1 + 23 * nstart);
            end
            nstart++;
         end
         if (bus.o_result_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid got valid=%b result=%h cycle=%0d", bus.o_result_valid, bus.o_result, cyc);
            end else begin
               e = sb.pop_front();
               exp_result = e.val;
               if (bus.o_result_valid !== e.vld || bus.o_result !== e.val || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result got valid=%b value=%h cycle=%0d required valid=%b value=%h cycle=%0d",
                           bus.o_result_valid, bus.o_result, cyc, e.vld, e.val, e.cyc);
               end
            end
            nvalid++;
            if (nvalid == 5) bus.i_req = '0;
         end
      end
      checks++;
      if (ngrant != 5) begin errors++; $display("FAIL rr_grant_count got %0d required 5", ngrant); end
      checks++;
      if (nstart != 5) begin errors++; $display("FAIL rr_start_count got %0d required 5", nstart); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rr_missing_results got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_single;
      exp_t e;
      int c, nstart;
      @(negedge clk);
      c = cyc;
      bus.i_req = 4'b0001;
      push_exp(0, c + 23);
      nstart = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (bus.o_grant !== 4'b0001 || bus.o_rng_start !== 1'b1 || bus.o_busy !== 1'b1) begin
               errors++;
               $display("FAIL single_launch got grant=%b start=%b busy=%b required 0001/1/1",
                        bus.o_grant, bus.o_rng_start, bus.o_busy);
            end
         end
         if (bus.o_rng_start === 1'b1) nstart++;
         if (k == 22) begin
            checks++;
            if (bus.o_busy !== 1'b1 || bus.o_grant !== 4'b0001) begin
               errors++;
               $display("FAIL single_capture_cycle got busy=%b grant=%b required 1/0001", bus.o_busy, bus.o_grant);
            end
         end
         if (k == 23) begin
            checks++;
            if (bus.o_busy !== 1'b0 || bus.o_grant !== 4'b0000) begin
               errors++;
               $display("FAIL single_idle_after got busy=%b grant=%b required 0/0000", bus.o_busy, bus.o_grant);
            end
         end
         if (bus.o_result_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid got valid=%b result=%h cycle=%0d", bus.o_result_valid, bus.o_result, cyc);
            end else begin
               e = sb.pop_front();
               exp_result = e.val;
               if (bus.o_result_valid !== e.vld || bus.o_result !== e.val || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result got valid=%b value=%h cycle=%0d required valid=%b value=%h cycle=%0d",
                           bus.o_result_valid, bus.o_result, cyc, e.vld, e.val, e.cyc);
               end
            end
            if (bus.o_result_valid[0] === 1'b1) bus.i_req[0] = 1'b0;
         end
         if (k == 28) begin
            checks++;
            if (bus.o_result !== exp_result) begin
               errors++;
               $display("FAIL single_result_hold got %h required %h", bus.o_result, exp_result);
            end
         end
      end
      checks++;
      if (nstart != 1) begin errors++; $display("FAIL single_start_count got %0d required 1", nstart); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL single_missing_result got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_pause;
      exp_t e;
      int c, nstart, npaused, first_p;
      @(negedge clk);
      c = cyc;
      bus.i_req = 4'b0010;
      push_exp(1, c + 55);
      nstart = 0; npaused = 0; first_p = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         bus.i_pause = '0;
         if (k == 7 || k == 38) bus.i_pause[1] = 1'b1;
         if (bus.o_rng_start === 1'b1) begin
            checks++;
            if (k != 1 && k != 8 && k != 39) begin
               errors++;
               $display("FAIL pause_start pulse at offset %0d required offsets 1/8/39", k);
            end
            nstart++;
         end
         if (bus.o_paused === 1'b1) begin
            if (first_p == 0) first_p = k;
            npaused++;
         end
         if (bus.o_result_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid got valid=%b result=%h cycle=%0d", bus.o_result_valid, bus.o_result, cyc);
            end else begin
               e = sb.pop_front();
               exp_result = e.val;
               if (bus.o_result_valid !== e.vld || bus.o_result !== e.val || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result got valid=%b value=%h cycle=%0d required valid=%b value=%h cycle=%0d",
                           bus.o_result_valid, bus.o_result, cyc, e.vld, e.val, e.cyc);
               end
            end
            if (bus.o_result_valid[1] === 1'b1) bus.i_req[1] = 1'b0;
         end
      end
      bus.i_pause = '0;
      checks++;
      if (nstart != 3) begin errors++; $display("FAIL pause_start_count got %0d required 3", nstart); end
      checks++;
      if (npaused != 30 || first_p != 9) begin
         errors++;
         $display("FAIL pause_window got %0d cycles from offset %0d required 30 from offset 9", npaused, first_p);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL pause_missing_result got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_guard;
      exp_t e;
      int c, nstart, npaused;
      @(negedge clk);
      c = cyc;
      bus.i_req = 4'b0100;
      push_exp(2, c + 23);
      nstart = 0; npaused = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         bus.i_pause = '0;
         if (k == 7) bus.i_pause = 4'b1011;
         if (k == 1 || k == 18 || k == 19 || k == 21 || k == 22) bus.i_pause[2] = 1'b1;
         if (bus.o_rng_start === 1'b1) begin
            checks++;
            if (k != 1) begin
               errors++;
               $display("FAIL guard_start pulse at offset %0d required offset 1 only", k);
            end
            nstart++;
         end
         if (bus.o_paused === 1'b1) npaused++;
         if (bus.o_result_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid got valid=%b result=%h cycle=%0d", bus.o_result_valid, bus.o_result, cyc);
            end else begin
               e = sb.pop_front();
               exp_result = e.val;
               if (bus.o_result_valid !== e.vld || bus.o_result !== e.val || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result got valid=%b value=%h cycle=%0d required valid=%b value=%h cycle=%0d",
                           bus.o_result_valid, bus.o_result, cyc, e.vld, e.val, e.cyc);
               end
            end
            if (bus.o_result_valid[2] === 1'b1) bus.i_req[2] = 1'b0;
         end
      end
      bus.i_pause = '0;
      checks++;
      if (nstart != 1 || npaused != 0) begin
         errors++;
         $display("FAIL guard_ignored got %0d pulses %0d paused cycles required 1 and 0", nstart, npaused);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL guard_missing_result got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_drop;
      exp_t e;
      int c, nstart, npaused;
      @(negedge clk);
      c = cyc;
      bus.i_req = 4'b1000;
      nstart = 0; npaused = 0;
      for (int k = 1; k <= 58; k++) begin
         @(negedge clk);
         bus.i_pause = '0;
         if (k == 7) bus.i_pause[3] = 1'b1;
         if (k == 12) bus.i_req[3] = 1'b0;
         if (bus.o_rng_start === 1'b1) begin
            checks++;
            if (k != 1 && k != 8 && k != 13 && k != 31) begin
               errors++;
               $display("FAIL drop_start pulse at offset %0d required offsets 1/8/13/31", k);
            end
            nstart++;
         end
         if (bus.o_paused === 1'b1) npaused++;
         if (k == 28) begin
            checks++;
            if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL drop_busy_capture got %b required 1", bus.o_busy); end
         end
         if (k == 29) begin
            checks++;
            if (bus.o_busy !== 1'b0 || bus.o_result !== exp_result) begin
               errors++;
               $display("FAIL drop_discard got busy=%b result=%h required 0/%h", bus.o_busy, bus.o_result, exp_result);
            end
         end
         if (k == 30) begin
            bus.i_req = 4'b1001;
            push_exp(0, c + 53);
         end
         if (k == 31) begin
            checks++;
            if (bus.o_grant !== 4'b0001) begin
               errors++;
               $display("FAIL drop_pointer_advance got grant=%b required 0001", bus.o_grant);
            end
            bus.i_req[3] = 1'b0;
         end
         if (bus.o_result_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid got valid=%b result=%h cycle=%0d", bus.o_result_valid, bus.o_result, cyc);
            end else begin
               e = sb.pop_front();
               exp_result = e.val;
               if (bus.o_result_valid !== e.vld || bus.o_result !== e.val || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result got valid=%b value=%h cycle=%0d required valid=%b value=%h cycle=%0d",
                           bus.o_result_valid, bus.o_result, cyc, e.vld, e.val, e.cyc);
               end
            end
            if (bus.o_result_valid[0] === 1'b1) bus.i_req[0] = 1'b0;
         end
      end
      bus.i_pause = '0;
      checks++;
      if (nstart != 4 || npaused != 4) begin
         errors++;
         $display("FAIL drop_resume got %0d pulses %0d paused cycles required 4 and 4", nstart, npaused);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL drop_missing_result got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int c;
      @(negedge clk);
      c = cyc;
      bus.i_req = 4'b0101;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (bus.o_grant !== 4'b0100) begin
               errors++;
               $display("FAIL rst_pre_grant got %b required 0100", bus.o_grant);
            end
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.o_grant, bus.o_result_valid, bus.o_result, bus.o_rng_start, bus.o_busy, bus.o_paused} !== 15'd0) begin
         errors++;
         $display("FAIL rst_async_clear got %h required 0",
                  {bus.o_grant, bus.o_result_valid, bus.o_result, bus.o_rng_start, bus.o_busy, bus.o_paused});
      end
      exp_result = '0;
      @(negedge clk);
      rst_n = 1'b1;
      c = cyc;
      push_exp(0, c + 23);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (bus.o_grant !== 4'b0001 || bus.o_rng_start !== 1'b1) begin
               errors++;
               $display("FAIL rst_regrant got grant=%b start=%b required 0001/1", bus.o_grant, bus.o_rng_start);
            end
         end
         if (bus.o_result_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid got valid=%b result=%h cycle=%0d", bus.o_result_valid, bus.o_result, cyc);
            end else begin
               e = sb.pop_front();
               exp_result = e.val;
               if (bus.o_result_valid !== e.vld || bus.o_result !== e.val || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result got valid=%b value=%h cycle=%0d required valid=%b value=%h cycle=%0d",
                           bus.o_result_valid, bus.o_result, cyc, e.vld, e.val, e.cyc);
               end
            end
            bus.i_req = '0;
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rst_missing_result got %0d pending required 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_pause();
      test_guard();
      test_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rng_roll_arbiter.md
Name: rng_roll_arbiter

Overview:
- Shares one LFSR dice/random generator (4-bit value, single i_start pulse input that both launches a roll and toggles pause) among N_REQ requesters.
- Round-robin grants a roll and drives the generator's start line.
- Times the roll, forwards pause/resume requests from the granted requester, captures the final value and returns it with a per-requester valid pulse.
- Sits between the player/key-debounce logic and the generator.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ROLL_CYCLES, 126000000, running (unpaused) cycles from start pulse to capture. Must exceed the generator's full run and FINISH latency plus 2.
- TMR_W, 27, timer width; 2^TMR_W > ROLL_CYCLES.
- PAUSE_GUARD, 16, i_pause ignored once timer >= ROLL_CYCLES-PAUSE_GUARD.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_req  in  N_REQ  per-requester roll request, level; held until own o_result_valid.
- i_pause  in  N_REQ  per-requester 1-cycle pause/resume toggle pulse.
- i_rng_value  in  4  generator output.
- o_rng_start  out  1  to generator i_start; 1-cycle pulses only.
- o_grant  out  N_REQ  one-hot current owner, 0 when idle.
- o_result  out  4  captured roll value, holds until next capture.
- o_result_valid  out  N_REQ  1-cycle pulse, one-hot, owner of o_result.
- o_busy  out  1  roll in progress (any non-IDLE state).
- o_paused  out  1  in PAUSED.

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk. All outputs 0, state IDLE, timer 0, RR pointer 0.
- States: IDLE, LAUNCH, ROLL, PAUSE_ON, PAUSED, PAUSE_OFF, CAPTURE.
- IDLE:
  - If any i_req bit is set, grant the first set bit at or after the pointer, wrapping.
  - o_grant is registered the same edge; go to LAUNCH.
- LAUNCH: o_rng_start=1 for exactly one cycle; timer cleared; go to ROLL.
- ROLL:
  - Timer +1 per cycle.
  - If timer==ROLL_CYCLES-1, go to CAPTURE.
  - Otherwise, if i_pause[owner] is set and timer<ROLL_CYCLES-PAUSE_GUARD, go to PAUSE_ON.
- PAUSE_ON: o_rng_start=1 for one cycle, timer frozen; go to PAUSED.
- PAUSED: timer frozen, o_paused=1. i_pause[owner] -> PAUSE_OFF.
- PAUSE_OFF: o_rng_start=1 for one cycle, timer frozen; go to ROLL.
- CAPTURE:
  - o_result<=i_rng_value.
  - o_result_valid[owner]=1 if i_req[owner] is still high, else no pulse (result discarded, o_result unchanged).
  - Pointer<=owner+1 mod N_REQ; o_grant cleared; go to IDLE.
- IDLE lasts ≥1 cycle between grants, so back-to-back rolls have ≥2 cycles between the CAPTURE edge and the next start pulse.
- o_rng_start never asserts in two consecutive cycles and never outside LAUNCH/PAUSE_ON/PAUSE_OFF.
- i_pause from non-owners is ignored always. Owner i_pause in IDLE/LAUNCH/CAPTURE/PAUSE_ON/PAUSE_OFF is ignored (not queued).
- If the owner drops i_req mid-roll, the roll still completes (the generator cannot abort). The pointer still advances. If in PAUSED with i_req low, the block auto-resumes via PAUSE_OFF.
- Simultaneous requests: round-robin fairness; each requester is served at most once per N_REQ grants while others wait.
- Timer wrap cannot occur (parameter rule); the timer saturates defensively at ROLL_CYCLES-1.
- Reset mid-roll: immediate return to reset values. The generator shares i_rst_n, so both resynchronise.

Test Plan:
- ROLL_CYCLES=20, generator model: i_req=0001 held -> o_grant=0001 next cycle. o_rng_start single pulse. CAPTURE 21 cycles after the pulse. o_result_valid=0001 for 1 cycle, o_result=model value. o_busy low after.
- i_req=1111 held continuously -> grant order 0001,0010,0100,1000,0001. Exactly one start pulse per roll, ≥2 cycles apart.
- i_pause[owner] at timer=5, resume after 30 cycles -> start pulses at pause and resume. o_paused high 30 cycles. Capture delayed by exactly 32 cycles vs unpaused.
- i_pause from non-owner, and owner pause at timer=ROLL_CYCLES-3 (PAUSE_GUARD=4) -> no extra start pulse, normal capture time.
- Owner drops i_req during PAUSED -> auto-resume pulse. No o_result_valid. Pointer advances to the next requester.
- Assert i_rst_n low mid-ROLL for 1 cycle -> all outputs 0 immediately. A held request is regranted starting from requester 0.
